// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hold/flush sequencing for PC, IF/ID and ID/EXE registers.
// Handles load-use, multi-cycle EXE ops and taken branches.
// Optional macro PIPE_STALL_CNT_EN builds the stall-cycle counter on stall_cnt.
// Ports:
//   in : clk, rst_n, id_rs1/id_rs2, id_use_rs1/id_use_rs2, ex_valid,
//        ex_rd, ex_is_load, ex_mc_start, br_taken
//   out: pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, mc_busy, stall_cnt
module pipe_hazard_ctrl #(
    parameter int RFW    = 5,
    parameter int MC_LAT = 4,
    parameter int CW     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [RFW-1:0] id_rs1,
    input  logic [RFW-1:0] id_rs2,
    input  logic           id_use_rs1,
    input  logic           id_use_rs2,
    input  logic           ex_valid,
    input  logic [RFW-1:0] ex_rd,
    input  logic           ex_is_load,
    input  logic           ex_mc_start,
    input  logic           br_taken,
    output logic           pc_en,
    output logic           ifid_en,
    output logic           ifid_flush,
    output logic           idexe_en,
    output logic           idexe_flush,
    output logic           mc_busy,
    output logic [31:0]    stall_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_LAST = 2'd2
    } state_t;

    // BUSY counts down to zero, then one LAST cycle releases the pipe.
    localparam logic [CW-1:0] LP_CNT_INIT =
        CW'((MC_LAT >= 3) ? (MC_LAT - 3) : 0);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_mc_cnt;
    logic [CW-1:0]   w_mc_cnt_nxt;
    logic            r_run;
    logic            w_lu;
    logic            w_rs1_hit;
    logic            w_rs2_hit;

    assign w_rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign w_lu      = ex_valid && ex_is_load && (ex_rd != '0)
                    && (w_rs1_hit || w_rs2_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mc_cnt <= '0;
            r_run    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
            r_run    <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mc_cnt_nxt = r_mc_cnt;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b1;
        idexe_en     = 1'b0;
        idexe_flush  = 1'b1;
        mc_busy      = 1'b0;
        if (!r_run) begin
            // Bubbles fill the pipe until the first edge after reset.
            w_state_nxt  = S_IDLE;
        end else begin
            ifid_flush  = 1'b0;
            idexe_flush = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idexe_en    = 1'b1;
                        idexe_flush = 1'b1;
                    end else if (ex_valid && ex_mc_start) begin
                        mc_busy = 1'b1;
                        if (MC_LAT == 2) begin
                            w_state_nxt = S_LAST;
                        end else begin
                            w_state_nxt  = S_BUSY;
                            w_mc_cnt_nxt = LP_CNT_INIT;
                        end
                    end else if (w_lu) begin
                        idexe_en    = 1'b1;
                        idexe_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idexe_en = 1'b1;
                    end
                end
                S_BUSY: begin
                    mc_busy = 1'b1;
                    if (r_mc_cnt == '0) begin
                        w_state_nxt = S_LAST;
                    end else begin
                        w_mc_cnt_nxt = r_mc_cnt - CW'(1);
                    end
                end
                S_LAST: begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idexe_en    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_run && !pc_en && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench with a per-cycle occupancy model.
// Two instances: MC_LAT=4 and MC_LAT=2.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_valid = 0;
    logic       ex_is_load = 0, ex_mc_start = 0, br_taken = 0;

    logic [5:0]  v[2];
    logic [31:0] sc[2];
    logic        pe4, ie4, if4, xe4, xf4, mb4;
    logic        pe2, ie2, if2, xe2, xf2, mb2;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RFW(5), .MC_LAT(4), .CW(4)) u4 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_mc_start(ex_mc_start), .br_taken(br_taken),
        .pc_en(pe4), .ifid_en(ie4), .ifid_flush(if4), .idexe_en(xe4),
        .idexe_flush(xf4), .mc_busy(mb4), .stall_cnt(sc[0])
    );

    pipe_hazard_ctrl #(.RFW(5), .MC_LAT(2), .CW(4)) u2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_mc_start(ex_mc_start), .br_taken(br_taken),
        .pc_en(pe2), .ifid_en(ie2), .ifid_flush(if2), .idexe_en(xe2),
        .idexe_flush(xf2), .mc_busy(mb2), .stall_cnt(sc[1])
    );

    // {pc_en, ifid_en, ifid_flush, idexe_en, idexe_flush, mc_busy}
    assign v[0] = {pe4, ie4, if4, xe4, xf4, mb4};
    assign v[1] = {pe2, ie2, if2, xe2, xf2, mb2};

    localparam logic [5:0] E_RST = 6'b001010;
    localparam logic [5:0] E_BR  = 6'b111110;
    localparam logic [5:0] E_MC  = 6'b000001;
    localparam logic [5:0] E_LU  = 6'b000110;
    localparam logic [5:0] E_RUN = 6'b110100;

    // Model: occ = cycles the current multi-cycle op has already held EXE.
    int      lat[2] = '{4, 2};
    int      occ[2] = '{0, 0};
    longint  scnt[2] = '{0, 0};
    bit      mrun = 0;
    bit      chk_en = 0;

    always @(negedge clk) begin
        logic [5:0]  e;
        logic [31:0] es;
        logic        lu;
        if (chk_en) begin
            lu = ex_valid && ex_is_load && (ex_rd != 0) &&
                 ((id_use_rs1 && id_rs1 == ex_rd) ||
                  (id_use_rs2 && id_rs2 == ex_rd));
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    e = E_RST;
                    occ[k] = 0;
                    scnt[k] = 0;
                end else if (!mrun) begin
                    e = E_RST;
                end else if (occ[k] == 0) begin
                    if (br_taken) e = E_BR;
                    else if (ex_valid && ex_mc_start) begin
                        e = E_MC;
                        occ[k] = 1;
                    end else if (lu) e = E_LU;
                    else e = E_RUN;
                end else if (occ[k] < lat[k] - 1) begin
                    e = E_MC;
                    occ[k] = occ[k] + 1;
                end else begin
                    e = E_RUN;
                    occ[k] = 0;
                end
                checks++;
                if (v[k] !== e) begin
                    errs++;
                    $display("FAIL model_out[%0d] t=%0t got=%b want=%b",
                             k, $time, v[k], e);
                end
`ifdef PIPE_STALL_CNT_EN
                es = 32'(scnt[k]);
`else
                es = 32'h0;
`endif
                checks++;
                if (sc[k] !== es) begin
                    errs++;
                    $display("FAIL model_cnt[%0d] t=%0t got=%0d want=%0d",
                             k, $time, sc[k], es);
                end
                if (rst_n && mrun && !e[5] && scnt[k] < 64'hFFFF_FFFF)
                    scnt[k] = scnt[k] + 1;
            end
        end
        mrun = rst_n;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setin(input logic vld, input logic ld,
                         input logic [4:0] rd, input logic mc,
                         input logic br, input logic u1,
                         input logic [4:0] r1, input logic u2,
                         input logic [4:0] r2);
        ex_valid = vld; ex_is_load = ld; ex_rd = rd;
        ex_mc_start = mc; br_taken = br;
        id_use_rs1 = u1; id_rs1 = r1;
        id_use_rs2 = u2; id_rs2 = r2;
        #1;
    endtask

    task automatic clr();
        setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_hold4", {26'd0, v[0]}, {26'd0, E_RST});
        end
        step();
        rst_n = 1'b1;
        clr();
        chk("rel_pre_run", {26'd0, v[0]}, {26'd0, E_RST});
        step();
        chk("rel_run4", {26'd0, v[0]}, {26'd0, E_RUN});
        chk("rel_run2", {26'd0, v[1]}, {26'd0, E_RUN});
    endtask

    logic [5:0] t4[4];
    logic [5:0] t2[4];

    initial begin
        t4 = '{E_MC, E_MC, E_MC, E_RUN};
        t2 = '{E_MC, E_RUN, E_MC, E_RUN};
        #1 rst_n = 1'b0;
        chk_en = 1;
        do_reset();

        step(); setin(1, 1, 5, 0, 0, 0, 0, 1, 5);
        chk("lu_rs2", {26'd0, v[0]}, {26'd0, E_LU});
        step(); clr();
        chk("lu_after", {26'd0, v[0]}, {26'd0, E_RUN});
        step(); setin(1, 1, 0, 0, 0, 1, 0, 1, 0);
        chk("lu_x0", {26'd0, v[0]}, {26'd0, E_RUN});
        step(); setin(0, 1, 7, 0, 0, 1, 7, 0, 0);
        chk("lu_novalid", {26'd0, v[0]}, {26'd0, E_RUN});
        step(); setin(1, 1, 7, 0, 0, 0, 7, 0, 0);
        chk("lu_nouse", {26'd0, v[0]}, {26'd0, E_RUN});
        step(); setin(1, 1, 7, 0, 0, 1, 7, 0, 3);
        chk("lu_rs1", {26'd0, v[0]}, {26'd0, E_LU});

        for (int i = 0; i < 4; i++) begin
            step(); setin(1, 0, 9, 1, i == 1, 0, 0, 0, 0);
            chk($sformatf("mc4_c%0d", i), {26'd0, v[0]}, {26'd0, t4[i]});
            chk($sformatf("mc2_c%0d", i), {26'd0, v[1]}, {26'd0, t2[i]});
        end
        step(); clr();

        for (int i = 0; i < 8; i++) begin
            step(); setin(1, 0, 9, 1, 0, 0, 0, 0, 0);
            if (i == 4) chk("b2b_start4", {26'd0, v[0]}, {26'd0, E_MC});
            if (i == 7) chk("b2b_last4", {26'd0, v[0]}, {26'd0, E_RUN});
        end
        step(); clr();

        step(); setin(1, 1, 5, 0, 1, 0, 0, 1, 5);
        chk("br_lu4", {26'd0, v[0]}, {26'd0, E_BR});
        chk("br_lu2", {26'd0, v[1]}, {26'd0, E_BR});
        step(); setin(1, 0, 5, 1, 1, 0, 0, 0, 0);
        chk("br_mc4", {26'd0, v[0]}, {26'd0, E_BR});
        step(); clr();
        chk("br_mc_after", {26'd0, v[0]}, {26'd0, E_RUN});

        do_reset();
        step(); setin(1, 1, 5, 0, 0, 0, 0, 1, 5);
        for (int i = 0; i < 4; i++) begin
            step(); setin(1, 0, 9, 1, 0, 0, 0, 0, 0);
        end
        step(); clr();
`ifdef PIPE_STALL_CNT_EN
        chk("scnt4", sc[0], 32'd4);
        chk("scnt2", sc[1], 32'd3);
`else
        chk("scnt4_off", sc[0], 32'd0);
        chk("scnt2_off", sc[1], 32'd0);
`endif

        step(); setin(1, 0, 9, 1, 0, 0, 0, 0, 0);
        step();
        step();
        chk("mid_busy", {31'd0, mb4}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {26'd0, v[0]}, {26'd0, E_RST});
        step();
        step(); rst_n = 1'b1; clr();
        step();
        chk("post_rst", {26'd0, v[0]}, {26'd0, E_RUN});
        chk("post_busy", {31'd0, mb4}, 32'd0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit that sequences the IF/ID and ID/EXE stage registers of the 5-stage RISC core.
- Generates enable (hold) and flush (bubble-insert) controls for three cases:
  - load-use data hazards;
  - multi-cycle EXE operations (mul/div);
  - taken branches resolved in EXE.
- Sits beside the decode stage; its outputs gate the PC register and both pipeline registers.

Parameters:
- RFW, 5, register-file index width
- MC_LAT, 4, total cycles a multi-cycle op occupies EXE (legal range 2..16)
- CW, 4, width of internal multi-cycle counter (must hold MC_LAT-1)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  RFW  source reg 1 of instruction in ID
- id_rs2  in  RFW  source reg 2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_valid  in  1  EXE holds a real instruction (not a bubble)
- ex_rd  in  RFW  destination reg of instruction in EXE
- ex_is_load  in  1  EXE instruction is a load
- ex_mc_start  in  1  EXE instruction is multi-cycle
- br_taken  in  1  branch in EXE resolved taken (redirect this cycle)
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a bubble
- idexe_en  out  1  ID/EXE register load enable
- idexe_flush  out  1  ID/EXE loads a bubble
- mc_busy  out  1  multi-cycle op in progress
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Clock and reset: clk, single domain; rst_n is asynchronous and active-low.
- Registered state:
  - FSM {IDLE, BUSY, LAST};
  - counter mc_cnt[CW-1:0];
  - run flag.
- Reset (rst_n=0), asynchronous:
  - FSM=IDLE, mc_cnt=0, run=0;
  - outputs forced pc_en=0, ifid_en=0, idexe_en=0, ifid_flush=1, idexe_flush=1, mc_busy=0.
- Reset release: run sets on the first clk edge with rst_n=1. Outputs stay at their reset values until run=1, so the pipeline fills with bubbles.
- Outputs are combinational from registered state and current inputs (Mealy); the FSM updates on the clk rising edge.
- Load-use hazard (lu), defined as ex_valid & ex_is_load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Register 0 never hazards.
- Priority in IDLE, highest first:
  1. br_taken: pc_en=1, ifid_en=1, ifid_flush=1, idexe_en=1, idexe_flush=1. lu and ex_mc_start are ignored; FSM stays IDLE.
  2. ex_valid & ex_mc_start: pc_en=ifid_en=idexe_en=0, no flush, mc_busy=1.
     - MC_LAT=2: next state LAST.
     - Otherwise: next state BUSY, mc_cnt=MC_LAT-3.
  3. lu: pc_en=0, ifid_en=0, idexe_en=1, idexe_flush=1 (one bubble, single cycle).
  4. Otherwise: all enables 1, flushes 0.
- BUSY: all enables 0, flushes 0, mc_busy=1. mc_cnt decrements; at mc_cnt==0 next state is LAST. br_taken and lu are ignored (the EXE op is neither a branch nor a load).
- LAST: enables 1, flushes 0, mc_busy=0. ex_mc_start is ignored (it is still the same instruction); next state IDLE.
- Multi-cycle result: the stall lasts exactly MC_LAT-1 consecutive cycles, so the op holds EXE for MC_LAT cycles.
- Back-to-back multi-cycle ops: a new op arriving in the cycle after LAST is accepted normally.
- Reset mid-operation (rst_n low in BUSY/LAST): immediate return to IDLE with reset outputs. The pending op is abandoned.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with run=1 & pc_en=0, saturating at 32'hFFFF_FFFF;
  - cleared by reset only.
- Undefined: stall_cnt is tied to 32'h0 and no counter logic is built. The port is present in both builds.

Test Plan:
- Reset: rst_n low 3 cycles then high → all enables 0 and both flushes 1 until the first edge after release, then pc_en=ifid_en=idexe_en=1.
- Load-use: ex_valid=1, ex_is_load=1, ex_rd=5, id_use_rs2=1, id_rs2=5 → exactly one cycle of pc_en=0, ifid_en=0, idexe_flush=1. Repeat with ex_rd=0 → no stall.
- Multi-cycle: MC_LAT=4, ex_mc_start=1 held → stall for exactly 3 cycles (IDLE→BUSY→BUSY→LAST), mc_busy=1 for those 3, enables=1 in the 4th cycle. With MC_LAT=2 → 1-cycle stall.
- Branch priority: br_taken=1 together with a load-use match → ifid_flush=1, idexe_flush=1, pc_en=1, no stall.
- Reset mid-op: rst_n low during the 2nd BUSY cycle → outputs take reset values immediately; after release, FSM=IDLE and mc_busy=0.
- PIPE_STALL_CNT_EN: load-use stall plus one MC_LAT=4 op → stall_cnt=4. Build without the macro → stall_cnt=0 throughout.
